memif_arbiter: RTL

//  Two-master round-robin arbiter sharing the single Avalon-MM local port of the SDRAM

---
 rtl/memif_pkg.sv | 20 ++
 rtl/memif_tag_fifo.sv | 49 ++++
 rtl/memif_arbiter.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/memif_pkg.sv
// rtl/memif_pkg.sv - grant, state and tag definitions for the memory interface arbiter
package memif_pkg;

    // One-hot grant indication
    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_M0   = 2'b01;
    localparam logic [1:0] GRANT_M1   = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_GRANT0 = 2'b01,
        ST_GRANT1 = 2'b10
    } arb_state_t;

    // A read tag is {master id, burstcount}
    function automatic int tag_width(input int burst_w);
        return 1 + burst_w;
    endfunction

endpackage

// File: rtl/memif_tag_fifo.sv
// rtl/memif_tag_fifo.sv - synchronous FIFO holding outstanding read tags
module memif_tag_fifo #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int             PTR_W   = $clog2(DEPTH);
    localparam logic [PTR_W:0] PTR_ONE = (PTR_W + 1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A slot freed by a pop in the same cycle may be refilled immediately
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                     (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign head    = mem[rd_ptr[PTR_W-1:0]];

    // Read/write pointers with wrap bit for full/empty detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Tag storage; contents are meaningless while empty so no reset
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[PTR_W-1:0]] <= push_data;
    end

endmodule

// File: rtl/memif_arbiter.sv
// rtl/memif_arbiter.sv - two-master round-robin arbiter for the SDRAM controller local port
module memif_arbiter
    import memif_pkg::*;
#(
    parameter int ADDR_W      = 25,
    parameter int DATA_W      = 16,
    parameter int BURST_W     = 4,
    parameter int MAX_PENDING = 8
) (
    input  logic               ref_clk,
    input  logic               reset_n,
    input  logic [ADDR_W-1:0]  m0_address,
    input  logic               m0_read,
    input  logic               m0_write,
    input  logic [BURST_W-1:0] m0_burstcount,
    input  logic [DATA_W-1:0]  m0_writedata,
    input  logic [1:0]         m0_byteenable,
    output logic               m0_waitrequest,
    output logic [DATA_W-1:0]  m0_readdata,
    output logic               m0_readdatavalid,
    input  logic [ADDR_W-1:0]  m1_address,
    input  logic               m1_read,
    input  logic               m1_write,
    input  logic [BURST_W-1:0] m1_burstcount,
    input  logic [DATA_W-1:0]  m1_writedata,
    input  logic [1:0]         m1_byteenable,
    output logic               m1_waitrequest,
    output logic [DATA_W-1:0]  m1_readdata,
    output logic               m1_readdatavalid,
    output logic [ADDR_W-1:0]  avm_address,
    output logic               avm_read,
    output logic               avm_write,
    output logic [BURST_W-1:0] avm_burstcount,
    output logic [DATA_W-1:0]  avm_writedata,
    output logic [1:0]         avm_byteenable,
    input  logic               avm_waitrequest,
    input  logic [DATA_W-1:0]  avm_readdata,
    input  logic               avm_readdatavalid,
    output logic [1:0]         grant_id,
    output logic               rsp_err
);

    localparam int               TAG_W    = tag_width(BURST_W);
    localparam logic [BURST_W-1:0] BC_ONE = BURST_W'(1);
    localparam logic [BURST_W:0] BEAT_ONE = (BURST_W + 1)'(1);

    arb_state_t         state;
    arb_state_t         state_nxt;
    logic               last_grant;
    logic               wr_active;
    logic [BURST_W-1:0] wr_remaining;
    logic [BURST_W-1:0] rsp_beats;

    logic               req0;
    logic               req1;
    logic               sel;
    logic               granted;
    logic               sel_read;
    logic               sel_write;
    logic [BURST_W-1:0] sel_bc;
    logic               cmd_rd;
    logic               cmd_wr;
    logic               can_push;
    logic               rd_accept;
    logic               wr_accept;
    logic               wr_last;
    logic               cmd_done;

    logic               tag_push;
    logic               tag_pop;
    logic               tag_full;
    logic               tag_empty;
    logic [TAG_W-1:0]   tag_head;
    logic               head_id;
    logic [BURST_W-1:0] head_bc;
    logic [BURST_W:0]   rsp_beats_inc;
    logic               rsp_hit;
    logic               rsp_last;

    assign req0      = m0_read | m0_write;
    assign req1      = m1_read | m1_write;
    assign sel       = (state == ST_GRANT1);
    assign granted   = (state != ST_IDLE);
    assign sel_read  = sel ? m1_read       : m0_read;
    assign sel_write = sel ? m1_write      : m0_write;
    assign sel_bc    = sel ? m1_burstcount : m0_burstcount;

    // Write wins if a master raises both strobes; a read needs a free tag slot
    assign cmd_wr    = granted & sel_write;
    assign cmd_rd    = granted & sel_read & ~sel_write;
    assign can_push  = ~tag_full | tag_pop;
    assign rd_accept = cmd_rd & can_push & ~avm_waitrequest;
    assign wr_accept = cmd_wr & ~avm_waitrequest;
    assign wr_last   = wr_active ? (wr_remaining == BC_ONE) : (sel_bc <= BC_ONE);
    assign cmd_done  = rd_accept | (wr_accept & wr_last);
    assign tag_push  = rd_accept;

    // Read responses follow the head tag; pop once its last beat arrives
    assign head_id       = tag_head[BURST_W];
    assign head_bc       = tag_head[BURST_W-1:0];
    assign rsp_beats_inc = {1'b0, rsp_beats} + BEAT_ONE;
    assign rsp_last      = (rsp_beats_inc >= {1'b0, head_bc});
    assign rsp_hit       = avm_readdatavalid & ~tag_empty;
    assign tag_pop       = rsp_hit & rsp_last;

    assign m0_readdata      = avm_readdata;
    assign m1_readdata      = avm_readdata;
    assign m0_readdatavalid = rsp_hit & ~head_id;
    assign m1_readdatavalid = rsp_hit & head_id;

    memif_tag_fifo #(
        .WIDTH (TAG_W),
        .DEPTH (MAX_PENDING)
    ) u_tag_fifo (
        .clk       (ref_clk),
        .rst_n     (reset_n),
        .push      (tag_push),
        .push_data ({sel, sel_bc}),
        .pop       (tag_pop),
        .full      (tag_full),
        .empty     (tag_empty),
        .head      (tag_head)
    );

    // Arbitration state register
    always_ff @(posedge ref_clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    // Registered round-robin pick in IDLE; grant held until the command completes
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (req0 && (!req1 || last_grant)) state_nxt = ST_GRANT0;
                else if (req1)                     state_nxt = ST_GRANT1;
            end
            ST_GRANT0, ST_GRANT1: begin
                if (cmd_done) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Steer the granted master onto the controller port and gate its waitrequest
    always_comb begin
        grant_id       = GRANT_NONE;
        m0_waitrequest = 1'b1;
        m1_waitrequest = 1'b1;
        avm_address    = sel ? m1_address    : m0_address;
        avm_writedata  = sel ? m1_writedata  : m0_writedata;
        avm_byteenable = sel ? m1_byteenable : m0_byteenable;
        avm_burstcount = sel_bc;
        avm_read       = cmd_rd & can_push;
        avm_write      = cmd_wr;
        case (state)
            ST_GRANT0: begin
                grant_id       = GRANT_M0;
                m0_waitrequest = avm_waitrequest | (cmd_rd & ~can_push);
            end
            ST_GRANT1: begin
                grant_id       = GRANT_M1;
                m1_waitrequest = avm_waitrequest | (cmd_rd & ~can_push);
            end
            default: ;
        endcase
    end

    // Round-robin history and write-burst beat countdown
    always_ff @(posedge ref_clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant   <= 1'b1;
            wr_active    <= 1'b0;
            wr_remaining <= '0;
        end else begin
            if (cmd_done) last_grant <= sel;
            if (wr_accept) begin
                if (wr_last) begin
                    wr_active    <= 1'b0;
                    wr_remaining <= '0;
                end else if (wr_active) begin
                    wr_remaining <= wr_remaining - BC_ONE;
                end else begin
                    wr_active    <= 1'b1;
                    wr_remaining <= sel_bc - BC_ONE;
                end
            end
        end
    end

    // Beats received for the head tag, and sticky flag for responses with no owner
    always_ff @(posedge ref_clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_beats <= '0;
            rsp_err   <= 1'b0;
        end else begin
            if (rsp_hit) rsp_beats <= rsp_last ? '0 : rsp_beats_inc[BURST_W-1:0];
            if (avm_readdatavalid && tag_empty) rsp_err <= 1'b1;
        end
    end

endmodule
